// File: rtl/l2_noc3_wb_tx.sv
// NoC3 writeback/ack transmitter: serializes one descriptor into header, address and optional 2 data flits.
// Optional perf counters (perf_msg_cnt, perf_stall_cnt) are built when L2_NOC3_TX_PERF_CNT_EN is defined.
module l2_noc3_wb_tx #(
    parameter logic [7:0] MSG_WB_REQ = 8'd12,
    parameter logic [7:0] MSG_ACK    = 8'd13,
    parameter logic [3:0] FBITS      = 4'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_has_data,
    input  logic [7:0]   req_mshrid,
    input  logic [39:0]  req_addr,
    input  logic [127:0] req_data,
    input  logic [13:0]  dst_chipid,
    input  logic [7:0]   dst_x,
    input  logic [7:0]   dst_y,
    output logic         noc3_valid_out,
    input  logic         noc3_ready_out,
    output logic [63:0]  noc3_data_out,
`ifdef L2_NOC3_TX_PERF_CNT_EN
    output logic [15:0]  perf_msg_cnt,
    output logic [15:0]  perf_stall_cnt,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, HDR, ADDR, D0, D1} state_e;

    state_e         state_q;
    logic           has_data_q;
    logic [35:0]    addr_q;
    logic [127:0]   line_q;
    logic [63:0]    flit_q;

    logic [63:0]    hdr_d;
    logic           last_flit;
    logic           accept;
    logic           unused_addr_lsb;

    // Line offset bits never reach the wire; the address flit is line-aligned.
    assign unused_addr_lsb = ^req_addr[3:0];

    assign hdr_d = {dst_chipid, dst_x, dst_y, FBITS,
                    req_has_data ? 8'd3 : 8'd1,
                    req_has_data ? MSG_WB_REQ : MSG_ACK,
                    req_mshrid, 6'b0};

    assign noc3_valid_out = (state_q != IDLE);
    assign busy           = (state_q != IDLE);
    assign noc3_data_out  = flit_q;

    // Accepting on the last-flit transfer lets the next header follow with no bubble.
    assign last_flit = ((state_q == ADDR) && !has_data_q) || (state_q == D1);
    assign req_ready = (state_q == IDLE) || (last_flit && noc3_ready_out);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            has_data_q <= 1'b0;
            addr_q     <= '0;
            line_q     <= '0;
            flit_q     <= '0;
        end else if (accept) begin
            state_q    <= HDR;
            has_data_q <= req_has_data;
            addr_q     <= req_addr[39:4];
            line_q     <= req_data;
            flit_q     <= hdr_d;
        end else begin
            case (state_q)
                HDR: if (noc3_ready_out) begin
                    state_q <= ADDR;
                    flit_q  <= {24'b0, addr_q, 4'b0};
                end
                ADDR: if (noc3_ready_out) begin
                    if (has_data_q) begin
                        state_q <= D0;
                        flit_q  <= line_q[63:0];
                    end else begin
                        state_q <= IDLE;
                        flit_q  <= '0;
                    end
                end
                D0: if (noc3_ready_out) begin
                    state_q <= D1;
                    flit_q  <= line_q[127:64];
                end
                D1: if (noc3_ready_out) begin
                    state_q <= IDLE;
                    flit_q  <= '0;
                end
                IDLE: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    flit_q  <= '0;
                end
            endcase
        end
    end

`ifdef L2_NOC3_TX_PERF_CNT_EN
    logic [15:0] msg_cnt_q;
    logic [15:0] stall_cnt_q;

    assign perf_msg_cnt   = msg_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (last_flit && noc3_ready_out && (msg_cnt_q != 16'hFFFF))
                msg_cnt_q <= msg_cnt_q + 16'd1;
            if (noc3_valid_out && !noc3_ready_out && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_noc3_wb_tx.sv
// Directed bench for l2_noc3_wb_tx: flit layout, flow control, back-to-back and mid-message reset.
module tb_l2_noc3_wb_tx;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_has_data;
    logic [7:0]   req_mshrid;
    logic [39:0]  req_addr;
    logic [127:0] req_data;
    logic [13:0]  dst_chipid;
    logic [7:0]   dst_x;
    logic [7:0]   dst_y;
    logic         noc3_valid_out;
    logic         noc3_ready_out;
    logic [63:0]  noc3_data_out;
    logic         busy;
`ifdef L2_NOC3_TX_PERF_CNT_EN
    logic [15:0]  perf_msg_cnt;
    logic [15:0]  perf_stall_cnt;
`endif

    int n_cmp;
    int n_bad;

    l2_noc3_wb_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_has_data   (req_has_data),
        .req_mshrid     (req_mshrid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .dst_chipid     (dst_chipid),
        .dst_x          (dst_x),
        .dst_y          (dst_y),
        .noc3_valid_out (noc3_valid_out),
        .noc3_ready_out (noc3_ready_out),
        .noc3_data_out  (noc3_data_out),
`ifdef L2_NOC3_TX_PERF_CNT_EN
        .perf_msg_cnt   (perf_msg_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic hd, input logic [7:0] id, input logic [39:0] a,
                           input logic [127:0] d, input logic [13:0] c,
                           input logic [7:0] x, input logic [7:0] y);
        req_has_data = hd;
        req_mshrid   = id;
        req_addr     = a;
        req_data     = d;
        dst_chipid   = c;
        dst_x        = x;
        dst_y        = y;
    endtask

    localparam logic [63:0]  HDR_A  = 64'h0000_0408_00C3_0140;
    localparam logic [63:0]  ADR_A  = 64'h0000_0012_3456_7890;
    localparam logic [127:0] DAT_A  = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [63:0]  HDR_K  = 64'h0A94_F30C_0043_7FC0;
    localparam logic [63:0]  ADR_K  = 64'h0000_00AB_CDEF_0120;
    localparam logic [63:0]  HDR_B  = 64'h0000_0408_00C3_0240;
    localparam logic [127:0] DAT_B  = {64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    localparam logic [63:0]  HDR_K2 = 64'h0000_0408_0043_41C0;

    logic [63:0] exp8 [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        noc3_ready_out = 1'b1;
        set_req(1'b0, 8'h0, 40'h0, 128'h0, 14'h0, 8'h0, 8'h0);
        tick();
        tick();
        chk("rst_valid", {63'b0, noc3_valid_out}, 64'd0);
        chk("rst_data", noc3_data_out, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_rdy", {63'b0, req_ready}, 64'd1);
        rst_n = 1'b1;
        tick();

        // WB with data, router always ready
        set_req(1'b1, 8'h05, 40'h12_3456_789A, DAT_A, 14'd0, 8'd1, 8'd2);
        req_valid = 1'b1;
        #1 chk("wb_idle_rdy", {63'b0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        chk("wb_hdr", noc3_data_out, HDR_A);
        chk("wb_hdr_vld", {63'b0, noc3_valid_out}, 64'd1);
        chk("wb_hdr_rdy", {63'b0, req_ready}, 64'd0);
        tick();
        chk("wb_addr", noc3_data_out, ADR_A);
        chk("wb_addr_rdy", {63'b0, req_ready}, 64'd0);
        tick();
        chk("wb_d0", noc3_data_out, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("wb_d0_rdy", {63'b0, req_ready}, 64'd0);
        tick();
        chk("wb_d1", noc3_data_out, 64'hBBBB_BBBB_BBBB_BBBB);
        chk("wb_d1_rdy", {63'b0, req_ready}, 64'd1);
        tick();
        chk("wb_done_vld", {63'b0, noc3_valid_out}, 64'd0);
        chk("wb_done_busy", {63'b0, busy}, 64'd0);

        // ACK with odd destination fields, 3-cycle stall on the address flit
        set_req(1'b0, 8'hFF, 40'hAB_CDEF_0123, 128'h0, 14'h2A5, 8'h3C, 8'hC3);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ack_hdr", noc3_data_out, HDR_K);
        tick();
        chk("ack_addr", noc3_data_out, ADR_K);
        noc3_ready_out = 1'b0;
        #1 chk("stall_rdy", {63'b0, req_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", noc3_data_out, ADR_K);
            chk("stall_vld", {63'b0, noc3_valid_out}, 64'd1);
            chk("stall_rdy_hold", {63'b0, req_ready}, 64'd0);
        end
        noc3_ready_out = 1'b1;
        #1 chk("ack_last_rdy", {63'b0, req_ready}, 64'd1);
        tick();
        chk("ack_busy", {63'b0, busy}, 64'd0);
        chk("ack_vld", {63'b0, noc3_valid_out}, 64'd0);
`ifdef L2_NOC3_TX_PERF_CNT_EN
        chk("perf_stall", {48'b0, perf_stall_cnt}, 64'd3);
        chk("perf_msg", {48'b0, perf_msg_cnt}, 64'd2);
`endif

        // Back-to-back: second descriptor waits in req_valid until D1 of the first
        exp8[0] = HDR_A;
        exp8[1] = ADR_A;
        exp8[2] = 64'hAAAA_AAAA_AAAA_AAAA;
        exp8[3] = 64'hBBBB_BBBB_BBBB_BBBB;
        exp8[4] = HDR_B;
        exp8[5] = 64'h0000_0000_0000_0010;
        exp8[6] = 64'hDDDD_DDDD_DDDD_DDDD;
        exp8[7] = 64'hCCCC_CCCC_CCCC_CCCC;
        set_req(1'b1, 8'h05, 40'h12_3456_789A, DAT_A, 14'd0, 8'd1, 8'd2);
        req_valid = 1'b1;
        tick();
        set_req(1'b1, 8'h09, 40'h00_0000_001F, DAT_B, 14'd0, 8'd1, 8'd2);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_vld", {63'b0, noc3_valid_out}, 64'd1);
            chk("b2b_flit", noc3_data_out, exp8[i]);
            if (i == 4) req_valid = 1'b0;
            tick();
        end
        chk("b2b_end", {63'b0, busy}, 64'd0);

        // Reset in D0 with a competing descriptor; reset must win
        set_req(1'b1, 8'h05, 40'h12_3456_789A, DAT_A, 14'd0, 8'd1, 8'd2);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_d0", noc3_data_out, 64'hAAAA_AAAA_AAAA_AAAA);
        rst_n = 1'b0;
        req_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        req_valid = 1'b0;
        chk("mrst_vld", {63'b0, noc3_valid_out}, 64'd0);
        chk("mrst_busy", {63'b0, busy}, 64'd0);
        #1 chk("mrst_rdy", {63'b0, req_ready}, 64'd1);
        set_req(1'b0, 8'h07, 40'hAB_CDEF_0123, 128'h0, 14'd0, 8'd1, 8'd2);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("post_rst_hdr", noc3_data_out, HDR_K2);
        tick();
        chk("post_rst_addr", noc3_data_out, ADR_K);
        tick();
        chk("post_rst_idle", {63'b0, busy}, 64'd0);
`ifdef L2_NOC3_TX_PERF_CNT_EN
        chk("perf_msg_rst", {48'b0, perf_msg_cnt}, 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
